// File: rtl/soc_system_switch_debounce_pkg.sv
// Shared switch-PIO definitions: board widths, debounce timing defaults and the per-bit FSM states.
package soc_system_switch_debounce_pkg;

  localparam int SW_WIDTH    = 4;
  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;

  // Cycles a new level must hold before it is accepted (20 ms @ 50 MHz = 1_000_000).
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEBOUNCE_CNT_W_DEF  = 20;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } db_state_e;

endpackage

// File: rtl/soc_system_debounce_bit.sv
// One switch bit: synchroniser chain, settle FSM with hold counter, and registered edge pulses.
module soc_system_debounce_bit
  import soc_system_switch_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = DEBOUNCE_CNT_W_DEF,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sw,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   smp;
  db_state_e              state;
  logic [CNT_W-1:0]       cnt;

  assign smp = sync_q[SYNC_STAGES-1];

  // New level has held for the full window; top registers the OR of these into changed.
  assign accept = (state == ST_SETTLE) && (smp != sw) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      state  <= ST_IDLE;
      cnt    <= '0;
      sw     <= RESET_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= accept & ~sw;
      fall   <= accept & sw;
      case (state)
        ST_IDLE: begin
          if (smp != sw) begin
            state <= ST_SETTLE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (smp == sw) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (accept) begin
            state <= ST_IDLE;
            sw    <= smp;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/soc_system_switch_debounce.sv
// Slide-switch conditioning for the switch PIO: per-bit synchronise + debounce, edge pulses, changed flag.
module soc_system_switch_debounce
  import soc_system_switch_debounce_pkg::*;
#(
  parameter int               WIDTH           = SW_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int               CNT_W           = DEBOUNCE_CNT_W_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_in[i]),
      .sw     (sw_out[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i]),
      .accept (accept[i])
    );
  end

  // Registered from the same acceptance terms as the pulses so it lines up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |accept;
  end

endmodule

// File: tb/tb_soc_system_switch_debounce.sv
// Scoreboard bench: stimulus queues expected pulse events, monitors pop and compare on changed.
module tb_soc_system_switch_debounce;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       rst_a, rst_b;
  logic [3:0] raw_a, raw_b;
  logic [3:0] sw_a, rise_a, fall_a, sw_b, rise_b, fall_b;
  logic       chg_a, chg_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  soc_system_switch_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4), .RESET_VALUE(4'h0)
  ) dut_a (
    .clk(clk), .reset(rst_a), .raw_in(raw_a),
    .sw_out(sw_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .changed(chg_a)
  );

  soc_system_switch_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(2), .RESET_VALUE(4'h0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .raw_in(raw_b),
    .sw_out(sw_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .changed(chg_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chg_a) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_pulse sw=%h rise=%h fall=%h cyc=%0d", sw_a, rise_a, fall_a, cyc);
      end else begin
        ea = qa.pop_front();
        if (sw_a !== ea.sw || rise_a !== ea.rise || fall_a !== ea.fall || cyc != ea.t) begin
          bad++;
          $display("FAIL a_event actual sw=%h rise=%h fall=%h cyc=%0d required sw=%h rise=%h fall=%h cyc=%0d",
                   sw_a, rise_a, fall_a, cyc, ea.sw, ea.rise, ea.fall, ea.t);
        end
      end
    end else if ((rise_a | fall_a) != 4'h0) begin
      total++;
      bad++;
      $display("FAIL a_pulse_without_changed rise=%h fall=%h cyc=%0d", rise_a, fall_a, cyc);
    end
  end

  always @(negedge clk) begin
    if (chg_b) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_pulse sw=%h rise=%h fall=%h cyc=%0d", sw_b, rise_b, fall_b, cyc);
      end else begin
        eb = qb.pop_front();
        if (sw_b !== eb.sw || rise_b !== eb.rise || fall_b !== eb.fall || cyc != eb.t) begin
          bad++;
          $display("FAIL b_event actual sw=%h rise=%h fall=%h cyc=%0d required sw=%h rise=%h fall=%h cyc=%0d",
                   sw_b, rise_b, fall_b, cyc, eb.sw, eb.rise, eb.fall, eb.t);
        end
      end
    end else if ((rise_b | fall_b) != 4'h0) begin
      total++;
      bad++;
      $display("FAIL b_pulse_without_changed rise=%h fall=%h cyc=%0d", rise_b, fall_b, cyc);
    end
  end

  // A raw change (or reset release) driven at the negedge where cyc==c is first sampled at
  // edge c+1; with 2 sync stages the accepted level appears after edge c+1+2+DEBOUNCE_CYCLES.
  initial begin
    int c;
    int r;
    rst_a = 1'b1; rst_b = 1'b1;
    raw_a = 4'hF; raw_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_sw_a", {28'd0, sw_a}, 32'h0);
    chk("rst_rise_a", {28'd0, rise_a}, 32'h0);
    chk("rst_fall_a", {28'd0, fall_a}, 32'h0);
    chk("rst_changed_a", {31'd0, chg_a}, 32'h0);
    chk("rst_sw_b", {28'd0, sw_b}, 32'h0);

    // 1: release with all switches high
    rst_a = 1'b0; rst_b = 1'b0;
    c = cyc;
    qa.push_back('{4'hF, 4'hF, 4'h0, c + 11});
    wait_until(c + 10); chk("t1_hold_low", {28'd0, sw_a}, 32'h0);
    wait_until(c + 11); chk("t1_accept", {28'd0, sw_a}, 32'hF);
    wait_until(c + 12); chk("t1_one_cycle", {31'd0, chg_a}, 32'h0);

    raw_a = 4'h0; c = cyc;
    qa.push_back('{4'h0, 4'h0, 4'hF, c + 11});
    wait_until(c + 14);

    // 2: short glitch on bit 0 is rejected
    raw_a = 4'h1;
    repeat (5) @(negedge clk);
    raw_a = 4'h0;
    repeat (20) @(negedge clk);
    chk("t2_glitch", {28'd0, sw_a}, 32'h0);

    // 3: bit 1 bounces every 3 cycles, then holds high
    for (int k = 0; k < 10; k++) begin
      raw_a[1] = ~raw_a[1];
      repeat (3) @(negedge clk);
    end
    chk("t3_bounce", {28'd0, sw_a}, 32'h0);
    raw_a[1] = 1'b1; c = cyc;
    qa.push_back('{4'b0010, 4'b0010, 4'b0000, c + 11});
    wait_until(c + 10); chk("t3_hold", {28'd0, sw_a}, 32'h0);
    wait_until(c + 14);

    // 4: simultaneous rise and fall on different bits
    raw_a = 4'b1000; c = cyc;
    qa.push_back('{4'b1000, 4'b1000, 4'b0010, c + 11});
    wait_until(c + 14);
    raw_a = 4'b0100; c = cyc;
    qa.push_back('{4'b0100, 4'b0100, 4'b1000, c + 11});
    wait_until(c + 10); chk("t4_hold", {28'd0, sw_a}, 32'h8);
    wait_until(c + 14);

    // 5: reset while bit 0 is settling (cnt==5 after edge c+7)
    raw_a = 4'b0101; c = cyc;
    wait_until(c + 7);
    rst_a = 1'b1;
    #1;
    chk("t5_rst_sw", {28'd0, sw_a}, 32'h0);
    chk("t5_rst_changed", {31'd0, chg_a}, 32'h0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; r = cyc;
    qa.push_back('{4'b0101, 4'b0101, 4'b0000, r + 11});
    wait_until(r + 10); chk("t5_full_latency", {28'd0, sw_a}, 32'h0);
    wait_until(r + 14);

    // 6: DEBOUNCE_CYCLES=1 instance
    raw_b = 4'h3; c = cyc;
    qb.push_back('{4'h3, 4'h3, 4'h0, c + 4});
    wait_until(c + 3); chk("t6_hold", {28'd0, sw_b}, 32'h0);
    wait_until(c + 4); chk("t6_accept", {28'd0, sw_b}, 32'h3);
    wait_until(c + 8);

    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
